// File: rtl/spi_master_ctrl.sv
// SPI master transfer sequencer, mode 0 (CPOL=0, CPHA=0), MSB first.
// One DATA_W-bit word per accepted start request. SCLK is derived from
// clk_in by a half-period counter; every output comes straight from a flop.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } state_t;

  state_t              state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   tx_sh_q,   tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q,   rx_sh_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic                sclk_q,    sclk_d;
  logic                mosi_q,    mosi_d;
  logic                cs_n_q,    cs_n_d;

  // A tick marks the last clk_in cycle of an SCLK half-period.
  logic tick;
  assign tick = (state_q != IDLE) && (cnt_q == CNT_W'(CLK_DIV - 1));

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; without these defaults synthesis would infer latches.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;

    if (state_q == IDLE || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tx_sh_d   = tx_data;
          mosi_d    = tx_data[DATA_W-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        // End of the MOSI setup half-period: first rising SCLK edge.
        if (tick) begin
          sclk_d    = 1'b1;
          rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso};
          bit_cnt_d = BIT_W'(1);
          state_d   = XFER;
        end
      end

      XFER: begin
        if (tick) begin
          if (sclk_q) begin
            // Falling edge: present the next bit unless the word is complete.
            sclk_d = 1'b0;
            if (bit_cnt_q != BIT_W'(DATA_W)) begin
              tx_sh_d = tx_sh_q << 1;
              mosi_d  = tx_sh_q[DATA_W-2];
            end
          end else if (bit_cnt_q == BIT_W'(DATA_W)) begin
            // Last low half-period done; SCLK stays low through HOLD.
            state_d = HOLD;
          end else begin
            // Rising edge: sample MISO into the receive shifter.
            sclk_d    = 1'b1;
            rx_sh_d   = {rx_sh_q[DATA_W-2:0], miso};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      HOLD: begin
        if (tick) begin
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          mosi_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule
